toggle_handshake_receiver: RTL and testbench

- Receiving end of the toggle-based request/acknowledge CDC link used to push a synchronization time value (BCD hh:mm:ss) into the clock domain.
- The sender flips req_tog per transfer through a toggle flop and holds data_in stable until ack_tog flips back.
- This block synchronizes req_tog, detects each toggle, captures data_in, presents it downstream with a valid/ready handshake, then toggles ack_tog.
- It also flags protocol overruns and counts accepted transfers.

---
 rtl/toggle_handshake_receiver_pkg.sv | 25 ++
 rtl/toggle_handshake_receiver_if.sv | 50 +++++
 rtl/toggle_handshake_receiver_bit_synchronizer.sv | 29 ++
 rtl/toggle_handshake_receiver.sv | 108 ++++++++++
 tb/tb_toggle_handshake_receiver.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/toggle_handshake_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module   : toggle_handshake_receiver_pkg
// Brief    : Shared types, defaults and helpers for the toggle CDC receiver.
// Revision : 1.0 - initial release
// ============================================================================
package toggle_handshake_receiver_pkg;

    localparam int DEFAULT_DATA_W      = 24;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_CNT_W       = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    // A request is outstanding whenever the synchronized toggle level differs
    // from the level of the last request that was taken.
    function automatic logic req_toggled(input logic req_level, input logic taken_level);
        return req_level ^ taken_level;
    endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_handshake_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : toggle_handshake_receiver_if
// Brief    : Sender, downstream and status signals of the toggle CDC receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface toggle_handshake_receiver_if
    import toggle_handshake_receiver_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = DEFAULT_CNT_W
) ();

    logic              req_tog;
    logic [DATA_W-1:0] data_in;
    logic              ack_tog;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              overrun;
    logic              err_clr;
    logic [CNT_W-1:0]  xfer_cnt;

    // master is everything around the receiver: sender, downstream sink, status.
    modport master (
        output req_tog,
        output data_in,
        output out_ready,
        output err_clr,
        input  ack_tog,
        input  out_data,
        input  out_valid,
        input  overrun,
        input  xfer_cnt
    );

    modport slave (
        input  req_tog,
        input  data_in,
        input  out_ready,
        input  err_clr,
        output ack_tog,
        output out_data,
        output out_valid,
        output overrun,
        output xfer_cnt
    );

endinterface
`default_nettype wire

// File: rtl/toggle_handshake_receiver_bit_synchronizer.sv
`default_nettype none
// ============================================================================
// Module   : toggle_handshake_receiver_bit_synchronizer
// Brief    : STAGES-deep flop chain bringing one async bit into clk domain.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_handshake_receiver_bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic async_i,
    output logic      sync_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/toggle_handshake_receiver.sv
`default_nettype none
// ============================================================================
// Module   : toggle_handshake_receiver
// Brief    : Receiving end of a toggle req/ack CDC link with valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module toggle_handshake_receiver
    import toggle_handshake_receiver_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_W       = DEFAULT_CNT_W
) (
    input wire logic                    clk,
    input wire logic                    reset,
    toggle_handshake_receiver_if.slave  bus
);

    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_HOLD = HOLD;

    logic [0:0]        state_q,     state_d;
    logic              req_prev_q,  req_prev_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              ack_q,       ack_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              overrun_q,   overrun_d;

    logic req_s;
    logic new_req;

    toggle_handshake_receiver_bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (bus.req_tog),
        .sync_o  (req_s)
    );

    assign new_req = req_toggled(req_s, req_prev_q);

    always_comb begin
        state_d     = state_q;
        req_prev_d  = req_prev_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ack_d       = ack_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // data_in is deliberately unsynchronized: the sender holds it
                // stable from its req flip until it sees our ack flip.
                if (new_req) begin
                    out_data_d  = bus.data_in;
                    req_prev_d  = req_s;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    ack_d       = ~ack_q;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A second toggle seen while holding is flagged but left pending, so it
        // is still taken as a fresh request once we are back in IDLE.
        overrun_d = ((state_q == ST_HOLD) && new_req) || (overrun_q && !bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_prev_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= 1'b0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_prev_q  <= req_prev_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ack_tog   = ack_q;
    assign bus.xfer_cnt  = cnt_q;
    assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_toggle_handshake_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_handshake_receiver
// Brief    : Randomized + directed bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_handshake_receiver;

    localparam int DATA_W      = 24;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    toggle_handshake_receiver_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    toggle_handshake_receiver #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: req_tog history in a queue gives the level visible
    // SYNC_STAGES edges later; the protocol is tracked as "busy / last taken level".
    bit              rq[$];
    bit              m_taken, m_busy, m_ack, m_ovr, m_live;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  m_cnt;

    always @(posedge clk) begin : model
        bit rs;
        bit was_busy;
        if (!reset) begin
            rq.delete();
            for (int i = 0; i < SYNC_STAGES; i++) rq.push_back(1'b0);
            m_taken = 1'b0;
            m_busy  = 1'b0;
            m_ack   = 1'b0;
            m_ovr   = 1'b0;
            m_data  = '0;
            m_cnt   = '0;
        end else begin
            rs = rq.pop_front();
            rq.push_back(bus.req_tog);
            was_busy = m_busy;
            m_ovr = (was_busy && (rs != m_taken)) || (m_ovr && !bus.err_clr);
            if (!was_busy) begin
                if (rs != m_taken) begin
                    m_data  = bus.data_in;
                    m_taken = rs;
                    m_busy  = 1'b1;
                end
            end else if (bus.out_ready) begin
                m_busy = 1'b0;
                m_ack  = !m_ack;
                m_cnt  = m_cnt + CNT_W'(1);
            end
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_busy));
            check("out_data",  32'(bus.out_data),  32'(m_data));
            check("ack_tog",   32'(bus.ack_tog),   32'(m_ack));
            check("overrun",   32'(bus.overrun),   32'(m_ovr));
            check("xfer_cnt",  32'(bus.xfer_cnt),  32'(m_cnt));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic v, input logic [DATA_W-1:0] d,
                       input logic a, input logic o, input logic [CNT_W-1:0] c);
        check({tag, ".valid"},   32'(bus.out_valid), 32'(v));
        check({tag, ".data"},    32'(bus.out_data),  32'(d));
        check({tag, ".ack"},     32'(bus.ack_tog),   32'(a));
        check({tag, ".overrun"}, 32'(bus.overrun),   32'(o));
        check({tag, ".cnt"},     32'(bus.xfer_cnt),  32'(c));
    endtask

    initial begin : watchdog
        #2_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit done;
        bus.req_tog   = 1'b1;
        bus.data_in   = 24'h123456;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;
        reset         = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step(1);
            lit("reset", 1'b0, 24'h0, 1'b0, 1'b0, 8'd0);
        end

        // Single transfer and its exact latency
        reset = 1'b1; bus.req_tog = 1'b0; bus.out_ready = 1'b1;
        step(3);
        bus.req_tog = 1'b1; bus.data_in = 24'h235959;
        step(2);
        check("lat.early_valid", 32'(bus.out_valid), 32'd0);
        step(1);
        lit("single", 1'b1, 24'h235959, 1'b0, 1'b0, 8'd0);
        step(1);
        lit("single_ack", 1'b0, 24'h235959, 1'b1, 1'b0, 8'd1);

        // Backpressure
        bus.out_ready = 1'b0; bus.req_tog = 1'b0; bus.data_in = 24'h010203;
        step(3);
        check("bp.valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus.data_in = 24'($urandom);
            step(1);
            lit("bp_hold", 1'b1, 24'h010203, 1'b1, 1'b0, 8'd1);
        end
        bus.out_ready = 1'b1;
        step(1);
        lit("bp_accept", 1'b0, 24'h010203, 1'b0, 1'b0, 8'd2);
        step(1);
        check("bp.ack_once", 32'(bus.ack_tog), 32'd0);

        // Overrun: extra toggle while holding is flagged, then taken
        bus.out_ready = 1'b0; bus.req_tog = 1'b1; bus.data_in = 24'h0A0B0C;
        step(3);
        check("ovr.valid", 32'(bus.out_valid), 32'd1);
        bus.req_tog = 1'b0; bus.data_in = 24'h111111;
        step(2);
        check("ovr.not_yet", 32'(bus.overrun), 32'd0);
        step(1);
        check("ovr.set", 32'(bus.overrun), 32'd1);
        bus.out_ready = 1'b1;
        step(1);
        lit("ovr_accept1", 1'b0, 24'h0A0B0C, 1'b1, 1'b1, 8'd3);
        step(1);
        lit("ovr_pending", 1'b1, 24'h111111, 1'b1, 1'b1, 8'd3);
        step(1);
        lit("ovr_accept2", 1'b0, 24'h111111, 1'b0, 1'b1, 8'd4);
        bus.err_clr = 1'b1;
        step(1);
        check("ovr.cleared", 32'(bus.overrun), 32'd0);

        // err_clr held across a fresh violation: set must win
        bus.err_clr = 1'b0; bus.out_ready = 1'b0; bus.req_tog = 1'b1; bus.data_in = 24'h222222;
        step(3);
        bus.err_clr = 1'b1; bus.req_tog = 1'b0;
        step(3);
        check("ovr.set_wins", 32'(bus.overrun), 32'd1);
        bus.req_tog = 1'b1;
        step(3);
        check("ovr.clr_after", 32'(bus.overrun), 32'd0);
        bus.err_clr = 1'b0; bus.out_ready = 1'b1;
        step(1);
        lit("netzero_accept", 1'b0, 24'h222222, 1'b1, 1'b0, 8'd5);
        step(4);
        check("netzero.no_extra", 32'(bus.xfer_cnt), 32'd5);

        // Counter wrap over 256 transfers with random backpressure
        reset = 1'b0; bus.req_tog = 1'b0; bus.out_ready = 1'b0;
        step(2);
        check("wrap.reset_cnt", 32'(bus.xfer_cnt), 32'd0);
        reset = 1'b1;
        step(2);
        for (int i = 0; i < 256; i++) begin
            bus.req_tog   = ~bus.req_tog;
            bus.data_in   = 24'(i);
            bus.out_ready = 1'($urandom_range(0, 1));
            done = 1'b0;
            for (int k = 0; k < 64 && !done; k++) begin
                step(1);
                if (bus.out_valid) check("wrap.data", 32'(bus.out_data), 32'(i));
                if (bus.ack_tog == bus.req_tog) done = 1'b1;
                bus.out_ready = 1'($urandom_range(0, 1));
            end
            if (!done) check("wrap.timeout", 32'd0, 32'd1);
        end
        step(1);
        check("wrap.cnt", 32'(bus.xfer_cnt), 32'd0);
        check("wrap.parity", 32'(bus.ack_tog), 32'(bus.req_tog));

        // Reset mid-transfer abandons it
        bus.out_ready = 1'b1; bus.req_tog = ~bus.req_tog; bus.data_in = 24'h000042;
        step(5);
        check("mid.pre_cnt", 32'(bus.xfer_cnt), 32'd1);
        bus.out_ready = 1'b0; bus.req_tog = ~bus.req_tog; bus.data_in = 24'hABCDEF;
        step(3);
        check("mid.valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b0; bus.req_tog = 1'b0;
        step(1);
        lit("mid_reset", 1'b0, 24'h0, 1'b0, 1'b0, 8'd0);
        reset = 1'b1; bus.out_ready = 1'b1;
        step(6);
        lit("mid_after", 1'b0, 24'h0, 1'b0, 1'b0, 8'd0);

        // Power-up mismatch: req_tog high out of reset gives exactly one transfer
        reset = 1'b0; bus.req_tog = 1'b1; bus.data_in = 24'h000777;
        step(2);
        reset = 1'b1;
        step(6);
        lit("powerup", 1'b0, 24'h000777, 1'b1, 1'b0, 8'd1);
        step(4);
        check("powerup.once", 32'(bus.xfer_cnt), 32'd1);

        // Random traffic including protocol violations and occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.req_tog = ~bus.req_tog;
                bus.data_in = 24'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.err_clr   = ($urandom_range(0, 15) == 0);
            reset         = ($urandom_range(0, 99) != 0);
            step(1);
        end
        reset = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
